// File: rtl/arbiter_fifo2pipeout_pkg.sv
// Shared constants, FSM state type and header-word formatter for the Neurram readout arbiter.
package neurram_io_pkg;

  localparam int unsigned NUM_CORES    = 8;
  localparam int unsigned WORD_W       = 32;
  localparam logic [7:0]  HEADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCheckAddr,
    StHeader,
    StTransfer,
    StDone
  } state_e;

  function automatic logic [WORD_W-1:0] header_word(logic [2:0] core, logic [9:0] nw);
    return {HEADER_MAGIC, 5'b0, core, 6'b0, nw};
  endfunction

endpackage

// File: rtl/arbiter_fifo2pipeout_if.sv
// Core-FIFO read side and pipe-out write side of the readout arbiter.
interface arbiter_fifo2pipeout_if;
  import neurram_io_pkg::*;

  logic [NUM_CORES*WORD_W-1:0] data_from_fifo;
  logic [NUM_CORES-1:0]        valid_from_fifo;
  logic [NUM_CORES-1:0]        rd_en_2fifo;
  logic [WORD_W-1:0]           dout;
  logic                        dout_write;
  logic                        dout_full;

  modport master (
    input  data_from_fifo, valid_from_fifo, dout_full,
    output rd_en_2fifo, dout, dout_write
  );

  modport slave (
    output data_from_fifo, valid_from_fifo, dout_full,
    input  rd_en_2fifo, dout, dout_write
  );

endinterface

// File: rtl/arbiter_fifo2pipeout_stall.sv
// Counts consecutive source-empty cycles; expired flags the last allowed empty cycle.
module stall_timeout_counter #(
  parameter logic [15:0] Limit = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == Limit - 16'd1);

endmodule

// File: rtl/arbiter_fifo2pipeout.sv
// Drains selected per-core result FIFOs, in ascending core order, into one pipe-out stream.
module arbiter_fifo2pipeout
  import neurram_io_pkg::*;
#(
  parameter bit          HEADER_EN      = 1'b1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_CORES-1:0]   core_select,
  input  logic [9:0]             num_words,
  arbiter_fifo2pipeout_if.master bus,
  output logic                   idle,
  output logic                   done,
  output logic [NUM_CORES-1:0]   timeout_flags
);

  state_e               state_q, state_d;
  logic [3:0]           addr_q, addr_d;
  logic [9:0]           word_cnt_q, word_cnt_d;
  logic [9:0]           nw_q, nw_d;
  logic [NUM_CORES-1:0] sel_q, sel_d;
  logic [NUM_CORES-1:0] flags_q, flags_d;
  logic [2:0]           cur;
  logic                 xfer, stall_inc, stall_clr, stall_expired, stall_en;

  assign cur           = addr_q[2:0];
  assign xfer          = bus.valid_from_fifo[cur] & ~bus.dout_full;
  assign stall_en      = (TIMEOUT_CYCLES != 16'd0);
  assign timeout_flags = flags_q;

  stall_timeout_counter #(
    .Limit (TIMEOUT_CYCLES)
  ) u_stall (
    .clk     (clk),
    .rst     (rst),
    .inc     (stall_inc),
    .clr     (stall_clr),
    .en      (stall_en),
    .expired (stall_expired)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    word_cnt_d      = word_cnt_q;
    nw_d            = nw_q;
    sel_d           = sel_q;
    flags_d         = flags_q;
    idle            = 1'b0;
    done            = 1'b0;
    stall_inc       = 1'b0;
    stall_clr       = 1'b0;
    bus.rd_en_2fifo = '0;
    bus.dout        = '0;
    bus.dout_write  = 1'b0;

    unique case (state_q)
      StIdle: begin
        idle = 1'b1;
        if (start) begin
          sel_d   = core_select;
          nw_d    = num_words;
          addr_d  = '0;
          flags_d = '0;
          state_d = StCheckAddr;
        end
      end
      StCheckAddr: begin
        stall_clr = 1'b1;
        if (addr_q == 4'd8) begin
          state_d = StDone;
        end else if (!sel_q[cur] || (!HEADER_EN && nw_q == '0)) begin
          addr_d = addr_q + 4'd1;
        end else begin
          word_cnt_d = '0;
          state_d    = HEADER_EN ? StHeader : StTransfer;
        end
      end
      StHeader: begin
        bus.dout       = header_word(cur, nw_q);
        bus.dout_write = ~bus.dout_full;
        if (!bus.dout_full) begin
          if (nw_q == '0) begin
            addr_d  = addr_q + 4'd1;
            state_d = StCheckAddr;
          end else begin
            state_d = StTransfer;
          end
        end
      end
      StTransfer: begin
        bus.dout             = bus.data_from_fifo[cur*WORD_W +: WORD_W];
        bus.dout_write       = xfer;
        bus.rd_en_2fifo[cur] = xfer;
        if (xfer) begin
          word_cnt_d = word_cnt_q + 10'd1;
          stall_clr  = 1'b1;
          if (word_cnt_q == nw_q - 10'd1) begin
            addr_d  = addr_q + 4'd1;
            state_d = StCheckAddr;
          end
        end else if (!bus.valid_from_fifo[cur]) begin
          // A full-only stall falls through here untouched: no count, no clear.
          stall_inc = 1'b1;
          if (stall_expired) begin
            flags_d[cur] = 1'b1;
            addr_d       = addr_q + 4'd1;
            state_d      = StCheckAddr;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      word_cnt_q <= '0;
      nw_q       <= '0;
      sel_q      <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      nw_q       <= nw_d;
      sel_q      <= sel_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_arbiter_fifo2pipeout.sv
// Scoreboard bench for the readout arbiter: FWFT core-FIFO model feeding the DUT, expected words
// queued before each start and compared against the captured pipe-out stream.
module tb_arbiter_fifo2pipeout;
  import neurram_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, start_nh;
  logic [7:0] core_select;
  logic [9:0] num_words;
  logic       idle, done, idle_nh, done_nh;
  logic [7:0] flags, flags_nh;

  always #5 clk = ~clk;

  arbiter_fifo2pipeout_if bus ();
  arbiter_fifo2pipeout_if bus_nh ();

  arbiter_fifo2pipeout #(.HEADER_EN(1'b1), .TIMEOUT_CYCLES(16'd8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .core_select(core_select), .num_words(num_words),
    .bus(bus.master), .idle(idle), .done(done), .timeout_flags(flags)
  );

  arbiter_fifo2pipeout #(.HEADER_EN(1'b0), .TIMEOUT_CYCLES(16'd8)) u_dut_nh (
    .clk(clk), .rst(rst), .start(start_nh), .core_select(core_select), .num_words(num_words),
    .bus(bus_nh.master), .idle(idle_nh), .done(done_nh), .timeout_flags(flags_nh)
  );

  assign bus_nh.data_from_fifo  = '0;
  assign bus_nh.valid_from_fifo = '1;
  assign bus_nh.dout_full       = 1'b0;

  // FWFT source model: core c holds words src_word(c, k) for k < avail[c].
  int         rp    [8];
  int         avail [8];
  logic [255:0] src_data;
  logic [7:0]   src_valid;

  function automatic logic [31:0] src_word(int c, int k);
    return {4'hD, 4'(c), 8'h00, 16'(k)};
  endfunction

  always_comb begin
    src_data  = '0;
    src_valid = '0;
    for (int c = 0; c < 8; c++) begin
      src_data[c*32 +: 32] = src_word(c, rp[c]);
      src_valid[c]         = (rp[c] < avail[c]);
    end
  end
  assign bus.data_from_fifo  = src_data;
  assign bus.valid_from_fifo = src_valid;

  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) if (bus.rd_en_2fifo[c]) rp[c] <= rp[c] + 1;
  end

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [7:0]  rd_mask, flags_before, flags_after;
  logic        idle_after, toggle_full;
  int          rd_while_full, wr_while_full, bad_onehot, done_pulses, first_wr;
  logic [31:0] e, g;

  task automatic push_core(input int c, input logic [9:0] nw, input int nread);
    exp_q.push_back({8'hA5, 5'b0, 3'(c), 6'b0, nw});
    for (int k = 0; k < nread; k++) exp_q.push_back(src_word(c, rp[c] + k));
  endtask

  // act_kind 1: pulse rst after cycle act_cyc; act_kind 2: second start with another mask.
  task automatic run_readout(input logic [7:0] mask, input logic [9:0] nw, input int budget,
                             input int act_cyc, input int act_kind, output int done_cyc);
    got_q.delete();
    rd_mask = '0; rd_while_full = 0; wr_while_full = 0; bad_onehot = 0; done_pulses = 0;
    first_wr = -1; done_cyc = -1;
    @(negedge clk);
    core_select = mask; num_words = nw; start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      if (toggle_full) bus.dout_full = ~bus.dout_full;
      #1;
      if (bus.dout_write) begin
        got_q.push_back(bus.dout);
        if (first_wr < 0) first_wr = cyc;
        if (bus.dout_full) wr_while_full++;
      end
      if (bus.rd_en_2fifo != 0 && bus.dout_full) rd_while_full++;
      if ((bus.rd_en_2fifo & (bus.rd_en_2fifo - 8'd1)) != 0) bad_onehot++;
      rd_mask = rd_mask | bus.rd_en_2fifo;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == act_cyc + 1) begin idle_after = idle; flags_after = flags; end
      if (cyc == act_cyc) begin
        flags_before = flags;
        if (act_kind == 1) rst = 1'b1;
        else if (act_kind == 2) begin core_select = 8'hC0; num_words = 10'd7; start = 1'b1; end
      end
      if (done_cyc >= 0 && act_kind != 1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_nh = 1'b0; core_select = '0; num_words = '0;
    bus.dout_full = 1'b0; toggle_full = 1'b0;
    for (int c = 0; c < 8; c++) avail[c] = 1000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_chk++; if (bus.dout_write !== 1'b0) $display("FAIL reset_write got=%b exp=0", bus.dout_write);
    else n_pass++;
    n_chk++; if (bus.rd_en_2fifo !== 8'h00) $display("FAIL reset_rden got=%h exp=00", bus.rd_en_2fifo);
    else n_pass++;
    n_chk++; if (bus.dout !== 32'h0) $display("FAIL reset_dout got=%h exp=0", bus.dout); else n_pass++;
    n_chk++; if (flags !== 8'h00) $display("FAIL reset_flags got=%h exp=00", flags); else n_pass++;
  endtask

  task automatic test_basic();
    int dc;
    push_core(0, 10'd3, 3);
    push_core(2, 10'd3, 3);
    run_readout(8'h05, 10'd3, 40, -10, 0, dc);
    n_chk++; if (got_q.size() != exp_q.size())
      $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL basic_word got=%h exp=%h", g, e); else n_pass++;
    end
    exp_q.delete();
    n_chk++; if (first_wr != 2) $display("FAIL basic_first_write got=%0d exp=2", first_wr); else n_pass++;
    // 1 start + 9 address checks + 2 x (header + 3 words)
    n_chk++; if (dc != 18) $display("FAIL basic_done_cycle got=%0d exp=18", dc); else n_pass++;
    n_chk++; if (rd_mask !== 8'h05) $display("FAIL basic_rd_mask got=%h exp=05", rd_mask); else n_pass++;
    n_chk++; if (bad_onehot != 0) $display("FAIL basic_onehot got=%0d exp=0", bad_onehot); else n_pass++;
  endtask

  task automatic test_backpressure();
    int dc;
    push_core(7, 10'd4, 4);
    bus.dout_full = 1'b0; toggle_full = 1'b1;
    run_readout(8'h80, 10'd4, 60, -10, 0, dc);
    toggle_full = 1'b0; bus.dout_full = 1'b0;
    n_chk++; if (got_q.size() != 5) $display("FAIL bp_count got=%0d exp=5", got_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL bp_word got=%h exp=%h", g, e); else n_pass++;
    end
    exp_q.delete();
    n_chk++; if (rd_while_full != 0) $display("FAIL bp_rd_full got=%0d exp=0", rd_while_full);
    else n_pass++;
    n_chk++; if (wr_while_full != 0) $display("FAIL bp_wr_full got=%0d exp=0", wr_while_full);
    else n_pass++;
    n_chk++; if (dc != 20) $display("FAIL bp_done_cycle got=%0d exp=20", dc); else n_pass++;
  endtask

  task automatic test_timeout();
    int dc;
    avail[3] = rp[3] + 2;
    push_core(3, 10'd5, 2);
    push_core(4, 10'd5, 5);
    run_readout(8'h18, 10'd5, 60, -10, 0, dc);
    n_chk++; if (got_q.size() != exp_q.size())
      $display("FAIL to_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL to_word got=%h exp=%h", g, e); else n_pass++;
    end
    exp_q.delete();
    // 4 checks + hdr + 2 words + 8 empty + check + hdr + 5 words + 4 checks + done
    n_chk++; if (dc != 27) $display("FAIL to_done_cycle got=%0d exp=27", dc); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (flags !== 8'h08) $display("FAIL to_flags got=%h exp=08", flags); else n_pass++;
    n_chk++; if (rd_mask !== 8'h18) $display("FAIL to_rd_mask got=%h exp=18", rd_mask); else n_pass++;
    avail[3] = 1000;
  endtask

  task automatic test_zero_count();
    int dc, writes, rd_seen;
    for (int c = 0; c < 8; c++) push_core(c, 10'd0, 0);
    run_readout(8'hFF, 10'd0, 40, -10, 0, dc);
    n_chk++; if (got_q.size() != 8) $display("FAIL zero_hdr_count got=%0d exp=8", got_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL zero_hdr_word got=%h exp=%h", g, e); else n_pass++;
    end
    exp_q.delete();
    n_chk++; if (rd_mask !== 8'h00) $display("FAIL zero_rd_mask got=%h exp=00", rd_mask); else n_pass++;
    n_chk++; if (dc != 18) $display("FAIL zero_done_cycle got=%0d exp=18", dc); else n_pass++;
    // Header-less instance: every core skipped, done after 1 + 9 cycles.
    writes = 0; rd_seen = 0; dc = -1;
    @(negedge clk);
    core_select = 8'hFF; num_words = 10'd0; start_nh = 1'b1;
    for (int cyc = 1; cyc <= 30 && dc < 0; cyc++) begin
      @(negedge clk);
      start_nh = 1'b0;
      #1;
      if (bus_nh.dout_write) writes++;
      if (bus_nh.rd_en_2fifo != 0) rd_seen++;
      if (done_nh) dc = cyc;
    end
    n_chk++; if (writes != 0) $display("FAIL zero_nh_writes got=%0d exp=0", writes); else n_pass++;
    n_chk++; if (rd_seen != 0) $display("FAIL zero_nh_rden got=%0d exp=0", rd_seen); else n_pass++;
    n_chk++; if (dc != 10) $display("FAIL zero_nh_done_cycle got=%0d exp=10", dc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dc;
    avail[1] = rp[1];
    // Core 1 times out by cycle 11; core 3 is mid-transfer at cycle 16.
    run_readout(8'h0A, 10'd5, 30, 16, 1, dc);
    n_chk++; if (flags_before !== 8'h02) $display("FAIL rstmid_flags_before got=%h exp=02",
      flags_before); else n_pass++;
    n_chk++; if (idle_after !== 1'b1) $display("FAIL rstmid_idle got=%b exp=1", idle_after);
    else n_pass++;
    n_chk++; if (flags_after !== 8'h00) $display("FAIL rstmid_flags got=%h exp=00", flags_after);
    else n_pass++;
    n_chk++; if (done_pulses != 0) $display("FAIL rstmid_done got=%0d exp=0", done_pulses); else n_pass++;
    avail[1] = 1000;
  endtask

  task automatic test_start_busy();
    int dc;
    push_core(1, 10'd4, 4);
    run_readout(8'h02, 10'd4, 40, 4, 2, dc);
    n_chk++; if (got_q.size() != exp_q.size())
      $display("FAIL busy_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL busy_word got=%h exp=%h", g, e); else n_pass++;
    end
    exp_q.delete();
    n_chk++; if (dc != 15) $display("FAIL busy_done_cycle got=%0d exp=15", dc); else n_pass++;
    n_chk++; if (rd_mask !== 8'h02) $display("FAIL busy_rd_mask got=%h exp=02", rd_mask); else n_pass++;
    repeat (20) @(negedge clk);
    #1;
    n_chk++; if (idle !== 1'b1) $display("FAIL busy_idle_after got=%b exp=1", idle); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_count();
    test_reset_mid();
    test_basic();
    test_start_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
